axi4_stream_byte_align: RTL and testbench
=========================================

# axi4_stream_byte_align

Strips a per-packet number of leading bytes (0 .. DATA_WIDTH_B-1) from an AXI4-Stream packet and repacks the remaining bytes so the output packet starts at byte lane 0. It is the receive-side inverse of the byte-shift block: a packet shifted by N bytes and then aligned with shift N comes back byte-identical. It sits in front of header parsers and DMA writers that require lane-0-aligned payload.

## Interface
- DATA_WIDTH, 32, tdata width in bits, multiple of 8
- ID_WIDTH, 1, tid width
- DEST_WIDTH, 1, tdest width
- USER_WIDTH, 1, tuser width
- DATA_WIDTH_B, DATA_WIDTH/8, bytes per beat (W)
- DATA_WIDTH_B_W, $clog2(DATA_WIDTH_B), width of shift_i
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- shift_i  input  DATA_WIDTH_B_W  leading bytes to drop; sampled on first beat of each packet
- pkt_i  slave axi4_stream_if  input packet stream
- pkt_o  master axi4_stream_if  aligned output stream, fully registered

## Operation
- shift_lock <= shift_i on accepted first beat; changes to shift_i mid-packet ignored. tid/tdest/tuser latched from first beat and driven on every output beat of that packet.
- Byte count per input beat: first and last beats count up to leftmost set tkeep bit (lower lanes treated as significant); middle beats count W.
- Output beat k = ({in[k+1], in[k]} >> 8*shift_lock) low W bytes; tstrb shifted identically; tkeep = ones in low tx_bytes lanes, tstrb ANDed with that mask.
- FSM in state typedef:
  - IDLE: hold empty. Accept first beat into hold. If it is also last: rx > shift_lock -> go FLUSH; else packet fully stripped, dropped, stay IDLE.
  - RUN: each accepted beat emits a combined word from hold + beat, beat becomes new hold. On last beat with rx_last <= shift_lock: combined word is final, tlast=1, tx_bytes = W - shift_lock + rx_last, go IDLE. With rx_last > shift_lock: combined word full (tlast=0), go FLUSH.
  - FLUSH: pkt_i.tready=0; emit hold >> shift_lock, tx_bytes = rx_last - shift_lock (single-beat packet: rx - shift_lock), tlast=1; go IDLE when loaded into output register.
- pkt_i.tready = (state != FLUSH) && (!pkt_o.tvalid || pkt_o.tready).
- Output byte total per packet = input bytes - shift_lock; zero-byte result produces no output beat.

## Timing
- Reset: pkt_o.tvalid/tlast 0, tdata/tkeep/tstrb/tid/tdest/tuser 0, state IDLE, shift_lock 0, pkt_i.tready 1 after deassertion.
- Latency: output beat k valid cycle after input beat k+1 accepted; flush beat one cycle after last input beat accepted.
- Throughput 1 beat/cycle under no backpressure; one bubble on input per packet requiring FLUSH.
- pkt_o holds tdata/tkeep/tlast stable while tvalid && !tready.
- Next packet's first beat accepted in the same cycle the previous packet's tlast output is loaded (IDLE entered), not earlier.
- Reset mid-packet: all state discarded; next accepted beat treated as first.

## Structure
- Package axi4_stream_align_pkg: state enum typedef (IDLE, RUN, FLUSH), byte-count function helpers.
- Sub-module axi4_stream_lmo_cnt: combinational leftmost-one tkeep byte counter, reusable by the byte-shift block.
- Estimated 200-300 lines RTL.

## Test plan
- W=4, shift=1, 3-beat packet bytes 0..11 full tkeep -> 3 beats: 1..4, 5..8, 9..11 with tkeep 0111, tlast on third.
- shift=2, 2-beat packet, last tkeep 0011 (6 bytes) -> 1 beat bytes 2..5, tkeep 1111, tlast, no FLUSH bubble.
- Single-beat tkeep 0111, shift=3 -> no output; following packet shift=0 passes unchanged.
- shift_i toggled every cycle during a 5-beat packet -> output uses first-beat value only; tid/tuser from first beat on all beats.
- 1000 random packets (1-20 beats, random shift, random tlast tkeep) with 50% random pkt_o.tready and pkt_i.tvalid -> scoreboard match of bytes, tlast, tid/tdest/tuser; shift-block -> align-block loopback byte-identical.
- Assert rst_i mid-packet with pkt_o stalled -> outputs 0 immediately; next packet aligned correctly.

Source files
------------

// File: rtl/axi4_stream_align_pkg.sv
// -----------------------------------------------------------------------------
// axi4_stream_align_pkg
//   Shared types and byte-count helpers for the AXI4-Stream byte align block.
//   The same helpers are meant to be reused by the companion byte-shift block.
//
//   Contents:
//     align_state_e : aligner FSM states (idle / run / flush)
//     tail_bytes()  : bytes on the final beat when the tail fits the combined word
//     flush_bytes() : bytes carried out by the trailing flush beat
//     needs_flush() : true when the held beat still has bytes past the strip point
// -----------------------------------------------------------------------------
package axi4_stream_align_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush
   } align_state_e;

   // Final beat produced from hold + last input beat: the hold contributes
   // w - shift bytes and the last beat contributes rx_last bytes.
   function automatic int unsigned tail_bytes(input int unsigned w,
                                              input int unsigned shift,
                                              input int unsigned rx_last);
      return w - shift + rx_last;
   endfunction

   function automatic int unsigned flush_bytes(input int unsigned rx,
                                               input int unsigned shift);
      return rx - shift;
   endfunction

   function automatic bit needs_flush(input int unsigned rx,
                                      input int unsigned shift);
      return rx > shift;
   endfunction

endpackage

// File: rtl/axi4_stream_lmo_cnt.sv
// -----------------------------------------------------------------------------
// axi4_stream_lmo_cnt
//   Combinational byte counter for a tkeep vector: returns the index of the
//   leftmost set bit plus one, so every lane below it counts as significant.
//   An all-zero vector counts as zero bytes.
//
//   Ports:
//     keep_i : tkeep of one beat
//     cnt_o  : number of significant bytes (0 .. KEEP_WIDTH)
// -----------------------------------------------------------------------------
module axi4_stream_lmo_cnt #(
   parameter int unsigned KEEP_WIDTH = 4,
   parameter int unsigned CNT_WIDTH  = $clog2(KEEP_WIDTH + 1)
) (
   input  logic [KEEP_WIDTH-1:0] keep_i,
   output logic [CNT_WIDTH-1:0]  cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
         if (keep_i[i]) begin
            cnt_o = CNT_WIDTH'(i + 1);
         end
      end
   end

endmodule

// File: rtl/axi4_stream_byte_align.sv
// -----------------------------------------------------------------------------
// axi4_stream_byte_align
//   Drops shift_i leading bytes from each AXI4-Stream packet and repacks the
//   rest so the output packet starts on byte lane 0. The shift, tid, tdest and
//   tuser are captured on the first beat and held for the whole packet.
//   The output stream is fully registered.
//
//   Ports:
//     clk_i, rst_i            : clock, asynchronous active-high reset
//     shift_i                 : leading bytes to drop, sampled on first beat
//     pkt_i_*                 : slave stream (tvalid/tready/tdata/tkeep/tstrb/
//                               tlast/tid/tdest/tuser)
//     pkt_o_*                 : master stream, same signal set, registered
// -----------------------------------------------------------------------------
module axi4_stream_byte_align
   import axi4_stream_align_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ID_WIDTH       = 1,
   parameter int unsigned DEST_WIDTH     = 1,
   parameter int unsigned USER_WIDTH     = 1,
   parameter int unsigned DATA_WIDTH_B   = DATA_WIDTH / 8,
   parameter int unsigned DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [DATA_WIDTH_B_W-1:0] shift_i,

   input  logic                      pkt_i_tvalid,
   output logic                      pkt_i_tready,
   input  logic [DATA_WIDTH-1:0]     pkt_i_tdata,
   input  logic [DATA_WIDTH_B-1:0]   pkt_i_tkeep,
   input  logic [DATA_WIDTH_B-1:0]   pkt_i_tstrb,
   input  logic                      pkt_i_tlast,
   input  logic [ID_WIDTH-1:0]       pkt_i_tid,
   input  logic [DEST_WIDTH-1:0]     pkt_i_tdest,
   input  logic [USER_WIDTH-1:0]     pkt_i_tuser,

   output logic                      pkt_o_tvalid,
   input  logic                      pkt_o_tready,
   output logic [DATA_WIDTH-1:0]     pkt_o_tdata,
   output logic [DATA_WIDTH_B-1:0]   pkt_o_tkeep,
   output logic [DATA_WIDTH_B-1:0]   pkt_o_tstrb,
   output logic                      pkt_o_tlast,
   output logic [ID_WIDTH-1:0]       pkt_o_tid,
   output logic [DEST_WIDTH-1:0]     pkt_o_tdest,
   output logic [USER_WIDTH-1:0]     pkt_o_tuser
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH_B + 1);

   // Packet state
   align_state_e              st_q, st_d;
   logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
   logic [DATA_WIDTH_B-1:0]   hold_strb_q, hold_strb_d;
   logic [CntW-1:0]           hold_bytes_q, hold_bytes_d;
   logic [DATA_WIDTH_B_W-1:0] shift_lock_q, shift_lock_d;
   logic [ID_WIDTH-1:0]       meta_id_q, meta_id_d;
   logic [DEST_WIDTH-1:0]     meta_dest_q, meta_dest_d;
   logic [USER_WIDTH-1:0]     meta_user_q, meta_user_d;

   // Output register
   logic                      out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
   logic [DATA_WIDTH_B-1:0]   out_keep_q, out_keep_d;
   logic [DATA_WIDTH_B-1:0]   out_strb_q, out_strb_d;
   logic                      out_last_q, out_last_d;
   logic [ID_WIDTH-1:0]       out_id_q, out_id_d;
   logic [DEST_WIDTH-1:0]     out_dest_q, out_dest_d;
   logic [USER_WIDTH-1:0]     out_user_q, out_user_d;

   // Beat being loaded into the output register
   logic                      load;
   logic [DATA_WIDTH-1:0]     ld_data;
   logic [DATA_WIDTH_B-1:0]   ld_strb;
   logic [DATA_WIDTH_B-1:0]   ld_mask;
   logic [CntW-1:0]           ld_bytes;
   logic                      ld_last;

   logic                      out_free;
   logic                      in_accept;
   logic [CntW-1:0]           rx_cnt;
   logic [DATA_WIDTH-1:0]     comb_data;
   logic [DATA_WIDTH_B-1:0]   comb_strb;
   logic [DATA_WIDTH-1:0]     flush_data;
   logic [DATA_WIDTH_B-1:0]   flush_strb;

   axi4_stream_lmo_cnt #(
      .KEEP_WIDTH (DATA_WIDTH_B),
      .CNT_WIDTH  (CntW)
   ) u_lmo_cnt (
      .keep_i (pkt_i_tkeep),
      .cnt_o  (rx_cnt)
   );

   assign out_free     = !out_valid_q || pkt_o_tready;
   assign pkt_i_tready = (st_q != StFlush) && out_free;
   assign in_accept    = pkt_i_tvalid && pkt_i_tready;

   // Combined word: the held beat sits in the low half, the new beat above it,
   // so shifting right by the strip amount yields the next aligned word.
   assign comb_data  = DATA_WIDTH'({pkt_i_tdata, hold_data_q} >> {shift_lock_q, 3'b000});
   assign comb_strb  = DATA_WIDTH_B'({pkt_i_tstrb, hold_strb_q} >> shift_lock_q);
   assign flush_data = hold_data_q >> {shift_lock_q, 3'b000};
   assign flush_strb = hold_strb_q >> shift_lock_q;

   always_comb begin
      st_d         = st_q;
      hold_data_d  = hold_data_q;
      hold_strb_d  = hold_strb_q;
      hold_bytes_d = hold_bytes_q;
      shift_lock_d = shift_lock_q;
      meta_id_d    = meta_id_q;
      meta_dest_d  = meta_dest_q;
      meta_user_d  = meta_user_q;
      load         = 1'b0;
      ld_data      = comb_data;
      ld_strb      = comb_strb;
      ld_bytes     = CntW'(DATA_WIDTH_B);
      ld_last      = 1'b0;

      unique case (st_q)
         StIdle: begin
            if (in_accept) begin
               hold_data_d  = pkt_i_tdata;
               hold_strb_d  = pkt_i_tstrb;
               hold_bytes_d = rx_cnt;
               shift_lock_d = shift_i;
               meta_id_d    = pkt_i_tid;
               meta_dest_d  = pkt_i_tdest;
               meta_user_d  = pkt_i_tuser;
               if (pkt_i_tlast) begin
                  // Single-beat packet: either flush what survives the strip
                  // or drop the packet entirely.
                  if (needs_flush(32'(rx_cnt), 32'(shift_i))) begin
                     st_d = StFlush;
                  end
               end else begin
                  st_d = StRun;
               end
            end
         end

         StRun: begin
            if (in_accept) begin
               load        = 1'b1;
               hold_data_d = pkt_i_tdata;
               hold_strb_d = pkt_i_tstrb;
               if (pkt_i_tlast) begin
                  if (needs_flush(32'(rx_cnt), 32'(shift_lock_q))) begin
                     hold_bytes_d = rx_cnt;
                     st_d         = StFlush;
                  end else begin
                     ld_last  = 1'b1;
                     ld_bytes = CntW'(tail_bytes(DATA_WIDTH_B, 32'(shift_lock_q), 32'(rx_cnt)));
                     st_d     = StIdle;
                  end
               end
            end
         end

         StFlush: begin
            if (out_free) begin
               load     = 1'b1;
               ld_data  = flush_data;
               ld_strb  = flush_strb;
               ld_bytes = CntW'(flush_bytes(32'(hold_bytes_q), 32'(shift_lock_q)));
               ld_last  = 1'b1;
               st_d     = StIdle;
            end
         end

         default: begin
            st_d = StIdle;
         end
      endcase
   end

   always_comb begin
      ld_mask = '0;
      for (int unsigned i = 0; i < DATA_WIDTH_B; i++) begin
         ld_mask[i] = (ld_bytes > CntW'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q && !pkt_o_tready;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_strb_d  = out_strb_q;
      out_last_d  = out_last_q;
      out_id_d    = out_id_q;
      out_dest_d  = out_dest_q;
      out_user_d  = out_user_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = ld_data;
         out_keep_d  = ld_mask;
         out_strb_d  = ld_strb & ld_mask;
         out_last_d  = ld_last;
         out_id_d    = meta_id_q;
         out_dest_d  = meta_dest_q;
         out_user_d  = meta_user_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q         <= StIdle;
         hold_data_q  <= '0;
         hold_strb_q  <= '0;
         hold_bytes_q <= '0;
         shift_lock_q <= '0;
         meta_id_q    <= '0;
         meta_dest_q  <= '0;
         meta_user_q  <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_strb_q   <= '0;
         out_last_q   <= 1'b0;
         out_id_q     <= '0;
         out_dest_q   <= '0;
         out_user_q   <= '0;
      end else begin
         st_q         <= st_d;
         hold_data_q  <= hold_data_d;
         hold_strb_q  <= hold_strb_d;
         hold_bytes_q <= hold_bytes_d;
         shift_lock_q <= shift_lock_d;
         meta_id_q    <= meta_id_d;
         meta_dest_q  <= meta_dest_d;
         meta_user_q  <= meta_user_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_strb_q   <= out_strb_d;
         out_last_q   <= out_last_d;
         out_id_q     <= out_id_d;
         out_dest_q   <= out_dest_d;
         out_user_q   <= out_user_d;
      end
   end

   assign pkt_o_tvalid = out_valid_q;
   assign pkt_o_tdata  = out_data_q;
   assign pkt_o_tkeep  = out_keep_q;
   assign pkt_o_tstrb  = out_strb_q;
   assign pkt_o_tlast  = out_last_q;
   assign pkt_o_tid    = out_id_q;
   assign pkt_o_tdest  = out_dest_q;
   assign pkt_o_tuser  = out_user_q;

endmodule

// File: tb/tb_axi4_stream_byte_align.sv
// -----------------------------------------------------------------------------
// tb_axi4_stream_byte_align
//   Directed and randomized bench for axi4_stream_byte_align (W = 4 bytes).
//   Packets are described as byte streams; the expected output is the same
//   stream with the leading shift bytes removed, chopped into 4-byte beats.
// -----------------------------------------------------------------------------
module tb_axi4_stream_byte_align;

   localparam int unsigned DW = 32;
   localparam int unsigned WB = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic [3:0]  strb;
      logic        last;
      logic        sop;
      logic        id;
      logic        dest;
      logic        user;
      logic [1:0]  shift;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  shift_i;
   logic        pkt_i_tvalid;
   logic        pkt_i_tready;
   logic [31:0] pkt_i_tdata;
   logic [3:0]  pkt_i_tkeep;
   logic [3:0]  pkt_i_tstrb;
   logic        pkt_i_tlast;
   logic        pkt_i_tid;
   logic        pkt_i_tdest;
   logic        pkt_i_tuser;
   logic        pkt_o_tvalid;
   logic        pkt_o_tready;
   logic [31:0] pkt_o_tdata;
   logic [3:0]  pkt_o_tkeep;
   logic [3:0]  pkt_o_tstrb;
   logic        pkt_o_tlast;
   logic        pkt_o_tid;
   logic        pkt_o_tdest;
   logic        pkt_o_tuser;

   always #5 clk_i = ~clk_i;

   axi4_stream_byte_align #(
      .DATA_WIDTH (DW),
      .ID_WIDTH   (1),
      .DEST_WIDTH (1),
      .USER_WIDTH (1)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .shift_i      (shift_i),
      .pkt_i_tvalid (pkt_i_tvalid),
      .pkt_i_tready (pkt_i_tready),
      .pkt_i_tdata  (pkt_i_tdata),
      .pkt_i_tkeep  (pkt_i_tkeep),
      .pkt_i_tstrb  (pkt_i_tstrb),
      .pkt_i_tlast  (pkt_i_tlast),
      .pkt_i_tid    (pkt_i_tid),
      .pkt_i_tdest  (pkt_i_tdest),
      .pkt_i_tuser  (pkt_i_tuser),
      .pkt_o_tvalid (pkt_o_tvalid),
      .pkt_o_tready (pkt_o_tready),
      .pkt_o_tdata  (pkt_o_tdata),
      .pkt_o_tkeep  (pkt_o_tkeep),
      .pkt_o_tstrb  (pkt_o_tstrb),
      .pkt_o_tlast  (pkt_o_tlast),
      .pkt_o_tid    (pkt_o_tid),
      .pkt_o_tdest  (pkt_o_tdest),
      .pkt_o_tuser  (pkt_o_tuser)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   beat_t       in_q[$];
   beat_t       exp_q[$];
   beat_t       obs_log[$];
   logic [7:0]  pb[$];
   logic        ps[$];
   bit          stall_prev = 1'b0;
   logic [40:0] stall_snap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Turn the byte stream in pb/ps into input beats, and the same stream minus
   // its first s bytes into expected output beats.
   task automatic add_pkt(input logic [1:0] s, input logic id, input logic dest,
                          input logic user, input bit rand_keep);
      int    n;
      int    nb;
      int    cnt;
      beat_t t;
      n  = pb.size();
      nb = (n + WB - 1) / WB;
      for (int b = 0; b < nb; b++) begin
         t   = '0;
         cnt = (b == nb - 1) ? n - (nb - 1) * WB : WB;
         for (int j = 0; j < WB; j++) begin
            if (j < cnt) begin
               t.data[8*j +: 8] = pb[b*WB + j];
               t.strb[j]        = ps[b*WB + j];
               t.keep[j]        = 1'b1;
               if (rand_keep && j < cnt - 1) t.keep[j] = 1'($urandom);
            end else begin
               t.data[8*j +: 8] = 8'($urandom);
               t.strb[j]        = 1'($urandom);
            end
         end
         t.last  = (b == nb - 1);
         t.sop   = (b == 0);
         t.shift = s;
         t.id    = (b == 0) ? id   : 1'($urandom);
         t.dest  = (b == 0) ? dest : 1'($urandom);
         t.user  = (b == 0) ? user : 1'($urandom);
         in_q.push_back(t);
      end
      for (int k = int'(s); k < n; k += WB) begin
         t   = '0;
         cnt = (n - k < WB) ? n - k : WB;
         for (int j = 0; j < cnt; j++) begin
            t.data[8*j +: 8] = pb[k + j];
            t.strb[j]        = ps[k + j];
            t.keep[j]        = 1'b1;
         end
         t.last = (k + WB >= n);
         t.id   = id;
         t.dest = dest;
         t.user = user;
         exp_q.push_back(t);
      end
   endtask

   task automatic check_out();
      beat_t       o;
      beat_t       e;
      logic [31:0] lm;
      o      = '0;
      o.data = pkt_o_tdata;
      o.keep = pkt_o_tkeep;
      o.strb = pkt_o_tstrb;
      o.last = pkt_o_tlast;
      o.id   = pkt_o_tid;
      o.dest = pkt_o_tdest;
      o.user = pkt_o_tuser;
      obs_log.push_back(o);
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         for (int j = 0; j < WB; j++) lm[8*j +: 8] = {8{e.keep[j]}};
         chk("tdata", 64'(o.data & lm), 64'(e.data));
         chk("tkeep", 64'(o.keep), 64'(e.keep));
         chk("tstrb", 64'(o.strb), 64'(e.strb));
         chk("tlast", 64'(o.last), 64'(e.last));
         chk("tmeta", 64'({o.id, o.dest, o.user}), 64'({e.id, e.dest, e.user}));
      end
   endtask

   // Cycle engine: entered just after a falling edge, returns on a falling edge.
   task automatic run(input int max_cyc, input int vpct, input int rpct, input bit expect_done);
      int    done_cnt;
      bit    done;
      bit    in_fire;
      bit    out_fire;
      beat_t b;
      done_cnt = 0;
      done     = 1'b0;
      for (int c = 0; c < max_cyc && !done; c++) begin
         if (in_q.size() != 0 && $urandom_range(99) < vpct) begin
            b            = in_q[0];
            pkt_i_tvalid = 1'b1;
            pkt_i_tdata  = b.data;
            pkt_i_tkeep  = b.keep;
            pkt_i_tstrb  = b.strb;
            pkt_i_tlast  = b.last;
            pkt_i_tid    = b.id;
            pkt_i_tdest  = b.dest;
            pkt_i_tuser  = b.user;
            shift_i      = b.sop ? b.shift : 2'($urandom);
         end else begin
            pkt_i_tvalid = 1'b0;
            pkt_i_tdata  = $urandom;
            pkt_i_tkeep  = 4'($urandom);
            pkt_i_tstrb  = 4'($urandom);
            pkt_i_tlast  = 1'($urandom);
            pkt_i_tid    = 1'($urandom);
            pkt_i_tdest  = 1'($urandom);
            pkt_i_tuser  = 1'($urandom);
            shift_i      = 2'($urandom);
         end
         pkt_o_tready = ($urandom_range(99) < rpct);
         #1;
         if (stall_prev) begin
            chk("stall_valid", 64'(pkt_o_tvalid), 64'd1);
            chk("stall_hold", 64'({pkt_o_tdata, pkt_o_tkeep, pkt_o_tstrb, pkt_o_tlast}),
                64'(stall_snap));
         end
         in_fire  = pkt_i_tvalid && pkt_i_tready;
         out_fire = pkt_o_tvalid && pkt_o_tready;
         if (out_fire) check_out();
         stall_prev = pkt_o_tvalid && !pkt_o_tready;
         stall_snap = {pkt_o_tdata, pkt_o_tkeep, pkt_o_tstrb, pkt_o_tlast};
         @(posedge clk_i);
         if (in_fire) b = in_q.pop_front();
         @(negedge clk_i);
         if (in_q.size() == 0 && exp_q.size() == 0 && !pkt_o_tvalid) done_cnt++;
         else done_cnt = 0;
         done = (done_cnt >= 4);
      end
      if (expect_done) chk("drain", 64'(done), 64'd1);
      pkt_i_tvalid = 1'b0;
   endtask

   task automatic fill_seq(input int n, input int base);
      pb.delete();
      ps.delete();
      for (int i = 0; i < n; i++) begin
         pb.push_back(8'(base + i));
         ps.push_back(1'b1);
      end
   endtask

   task automatic fill_rand(input int n);
      pb.delete();
      ps.delete();
      for (int i = 0; i < n; i++) begin
         pb.push_back(8'($urandom));
         ps.push_back(1'($urandom));
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      shift_i      = '0;
      pkt_i_tvalid = 1'b0;
      pkt_i_tdata  = '0;
      pkt_i_tkeep  = '0;
      pkt_i_tstrb  = '0;
      pkt_i_tlast  = 1'b0;
      pkt_i_tid    = 1'b0;
      pkt_i_tdest  = 1'b0;
      pkt_i_tuser  = 1'b0;
      pkt_o_tready = 1'b0;

      // Reset values
      #12;
      chk("rst_tvalid", 64'(pkt_o_tvalid), 64'd0);
      chk("rst_tlast", 64'(pkt_o_tlast), 64'd0);
      chk("rst_tdata", 64'(pkt_o_tdata), 64'd0);
      chk("rst_tkeep_tstrb", 64'({pkt_o_tkeep, pkt_o_tstrb}), 64'd0);
      chk("rst_meta", 64'({pkt_o_tid, pkt_o_tdest, pkt_o_tuser}), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rst_tready", 64'(pkt_i_tready), 64'd1);
      @(negedge clk_i);

      // Shift 1, three full beats of bytes 0..11
      fill_seq(12, 0);
      add_pkt(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      obs_log.delete();
      run(100, 100, 100, 1'b1);
      chk("t1_beats", 64'(obs_log.size()), 64'd3);
      if (obs_log.size() == 3) begin
         chk("t1_b0_data", 64'(obs_log[0].data), 64'h04030201);
         chk("t1_b1_data", 64'(obs_log[1].data), 64'h08070605);
         chk("t1_b2_data", 64'(obs_log[2].data & 32'h00ffffff), 64'h000b0a09);
         chk("t1_b2_keep", 64'(obs_log[2].keep), 64'h7);
         chk("t1_lasts", 64'({obs_log[0].last, obs_log[1].last, obs_log[2].last}), 64'b001);
      end

      // Shift 2, six bytes: tail fits, one full final beat
      fill_seq(6, 0);
      add_pkt(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      obs_log.delete();
      run(100, 100, 100, 1'b1);
      chk("t2_beats", 64'(obs_log.size()), 64'd1);
      if (obs_log.size() == 1) begin
         chk("t2_data", 64'(obs_log[0].data), 64'h05040302);
         chk("t2_keep_last", 64'({obs_log[0].keep, obs_log[0].last}), 64'b11111);
      end

      // Fully stripped single beat, then an unshifted packet
      fill_seq(3, 8'h40);
      add_pkt(2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      fill_seq(5, 8'h10);
      add_pkt(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      obs_log.delete();
      run(100, 100, 100, 1'b1);
      chk("t3_beats", 64'(obs_log.size()), 64'd2);
      if (obs_log.size() == 2) begin
         chk("t3_b0_data", 64'(obs_log[0].data), 64'h13121110);
         chk("t3_b1", 64'({obs_log[1].keep, obs_log[1].data[7:0]}), 64'h114);
      end

      // Five-beat packet; the engine toggles shift_i and non-first metadata
      fill_rand(20);
      add_pkt(2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      obs_log.delete();
      run(100, 100, 100, 1'b1);
      chk("t4_beats", 64'(obs_log.size()), 64'd5);
      for (int i = 0; i < obs_log.size(); i++) begin
         chk("t4_tid_tuser", 64'({obs_log[i].id, obs_log[i].user}), 64'b11);
      end

      // Random packets under random valid/ready
      for (int p = 0; p < 1000; p++) begin
         fill_rand((int'($urandom_range(1, 20)) - 1) * WB + int'($urandom_range(1, 4)));
         add_pkt(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
      run(80000, 50, 50, 1'b1);

      // Reset while the output is stalled mid-packet
      fill_seq(12, 8'h80);
      add_pkt(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      run(6, 100, 0, 1'b0);
      chk("pre_rst_stalled", 64'(pkt_o_tvalid), 64'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("mid_rst_tvalid", 64'(pkt_o_tvalid), 64'd0);
      chk("mid_rst_out", 64'({pkt_o_tdata, pkt_o_tkeep, pkt_o_tstrb, pkt_o_tlast}), 64'd0);
      chk("mid_rst_tready", 64'(pkt_i_tready), 64'd1);
      in_q.delete();
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      fill_rand(9);
      add_pkt(2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      obs_log.delete();
      run(300, 50, 50, 1'b1);
      chk("post_rst_beats", 64'(obs_log.size()), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
